// File: rtl/seg_pace_pkg.sv
// Shared types and defaults for the segment step pacer.
package seg_pace_pkg;

  localparam int unsigned PRESCALE_W_DEF      = 12;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned AUTOREPEAT_TICKS    = 8;
  localparam int unsigned HOLD_W              = 3;
  localparam int unsigned RATE_W              = 4;
  localparam int unsigned COUNT_W             = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STEP_HOLD = 2'd1,
    RUN       = 2'd2
  } pace_state_e;

  // Output pin map of the 8-bit wrapper, MSB first.
  typedef struct packed {
    logic               heartbeat;
    logic [COUNT_W-1:0] count;
    logic               btn_db;
    logic               run_led;
    logic               adv;
  } pace_out_t;

endpackage

// File: rtl/seg_step_pacer_btn_debounce.sv
// Two-flop synchroniser plus level debouncer for the raw step button.
module btn_debounce
  import seg_pace_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_db
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;

  // A level change is accepted only after the counter has run up uninterrupted.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    db_d    = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
        db_d  = sync2_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  assign btn_db = db_q;

endmodule

// File: rtl/seg_step_pacer.sv
// Step/run pacer producing single-cycle advance strobes and a 4-bit step count.
// Build option: define STEP_AUTOREPEAT_EN to auto-repeat strobes while the button is held.
module seg_step_pacer
  import seg_pace_pkg::*;
#(
  parameter int unsigned PRESCALE_W      = PRESCALE_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  logic              clk;
  logic              rst;
  logic              btn_db;
  logic [RATE_W-1:0] rate;

  assign clk  = io_in[0];
  assign rst  = io_in[1];
  assign rate = io_in[7:4];

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (io_in[2]),
    .btn_db  (btn_db)
  );

  logic                  run_s1_q, run_s1_d;
  logic                  run_s2_q, run_s2_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  pace_state_e           state_q, state_d;
  logic                  adv_q, adv_d;
  logic                  run_led_q, run_led_d;
  logic                  btn_prev_q, btn_prev_d;
  logic [COUNT_W-1:0]    count_q, count_d;
`ifdef STEP_AUTOREPEAT_EN
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic                  hold_arm_q, hold_arm_d;
`endif

  int unsigned k_c;
  logic        tick_c;

  // Rate select is clamped to the prescaler width; tick when the low k+1 bits are all ones.
  always_comb begin
    k_c    = (32'(rate) > PRESCALE_W - 1) ? PRESCALE_W - 1 : 32'(rate);
    tick_c = 1'b1;
    for (int unsigned i = 0; i < PRESCALE_W; i++) begin
      if (i <= k_c && !pre_q[i]) tick_c = 1'b0;
    end
  end

  always_comb begin
    run_s1_d   = io_in[3];
    run_s2_d   = run_s1_q;
    pre_d      = pre_q + PRESCALE_W'(1);
    state_d    = state_q;
    adv_d      = 1'b0;
    btn_prev_d = btn_db;
    count_d    = adv_q ? count_q + COUNT_W'(1) : count_q;
`ifdef STEP_AUTOREPEAT_EN
    hold_cnt_d = '0;
    hold_arm_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        // A button edge takes priority over a pending run request.
        if (btn_db && !btn_prev_q) begin
          adv_d   = 1'b1;
          state_d = STEP_HOLD;
        end else if (run_s2_q) begin
          state_d = RUN;
        end
      end
      STEP_HOLD: begin
        if (!btn_db) begin
          state_d = IDLE;
        end else begin
`ifdef STEP_AUTOREPEAT_EN
          hold_cnt_d = hold_cnt_q;
          hold_arm_d = hold_arm_q;
          if (tick_c) begin
            if (hold_arm_q) begin
              adv_d = 1'b1;
            end else if (hold_cnt_q == HOLD_W'(AUTOREPEAT_TICKS - 1)) begin
              hold_arm_d = 1'b1;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
`endif
        end
      end
      RUN: begin
        if (!run_s2_q) begin
          state_d = IDLE;
        end else begin
          adv_d = tick_c;
        end
      end
      default: state_d = IDLE;
    endcase

    run_led_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1_q   <= 1'b0;
      run_s2_q   <= 1'b0;
      pre_q      <= '0;
      state_q    <= IDLE;
      adv_q      <= 1'b0;
      run_led_q  <= 1'b0;
      btn_prev_q <= 1'b0;
      count_q    <= '0;
`ifdef STEP_AUTOREPEAT_EN
      hold_cnt_q <= '0;
      hold_arm_q <= 1'b0;
`endif
    end else begin
      run_s1_q   <= run_s1_d;
      run_s2_q   <= run_s2_d;
      pre_q      <= pre_d;
      state_q    <= state_d;
      adv_q      <= adv_d;
      run_led_q  <= run_led_d;
      btn_prev_q <= btn_prev_d;
      count_q    <= count_d;
`ifdef STEP_AUTOREPEAT_EN
      hold_cnt_q <= hold_cnt_d;
      hold_arm_q <= hold_arm_d;
`endif
    end
  end

  pace_out_t pins;

  always_comb begin
    pins.heartbeat = pre_q[PRESCALE_W-1];
    pins.count     = count_q;
    pins.btn_db    = btn_db;
    pins.run_led   = run_led_q;
    pins.adv       = adv_q;
  end

  assign io_out = pins;

endmodule

// File: tb/tb_seg_step_pacer.sv
// Directed bench for seg_step_pacer with an adv-strobe scoreboard keyed by cycle number.
module tb_seg_step_pacer;

  logic       clk;
  logic       rst, btn, run;
  logic [3:0] rate;
  logic [7:0] io_in, io_out;

  assign io_in = {rate, run, btn, rst, clk};

  seg_step_pacer dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;
  int         r_edge = 0;
  logic [3:0] exp_cnt = 4'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Pop expected strobes as they fall due; every observed strobe must match one.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      check("adv_missing", cyc, mon_e.cyc);
    end
    if (io_out[0] === 1'b1) begin
      if (sb.size() == 0) begin
        check("adv_unexpected", cyc, -1);
      end else begin
        mon_e = sb.pop_front();
        check("adv_cycle", cyc, mon_e.cyc);
        check("adv_count", io_out[6:3], mon_e.cnt);
      end
    end
  end

  function automatic void push_adv(input int c);
    sb.push_back('{cyc: c, cnt: exp_cnt});
    exp_cnt = exp_cnt + 4'd1;
  endfunction

  function automatic int k_of(input logic [3:0] r);
    return (r > 4'd11) ? 11 : int'(r);
  endfunction

  // Prescaler value after edge n is (n - r_edge), r_edge being the last edge with reset high.
  function automatic bit tick_at(input int n, input int k);
    int p;
    p = 2 << k;
    return ((n - r_edge) % p) == (p - 1);
  endfunction

  function automatic void push_run(input int m_first, input int m_last, input int k);
    for (int m = m_first; m <= m_last; m++) begin
      if (tick_at(m - 1, k)) push_adv(m);
    end
  endfunction

  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic neg_at(input int c);
    goto_cyc(c);
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, cr, j;

    // Reset held with button and run asserted.
    rst = 1'b1; btn = 1'b1; run = 1'b1; rate = 4'd0;
    for (int i = 1; i <= 3; i++) begin
      neg_at(i);
      check("reset_hold_out", io_out, 8'h00);
    end
    rst = 1'b0; btn = 1'b0; run = 1'b0;
    r_edge = 3;
    neg_at(4);
    check("reset_release_out", io_out, 8'h00);

    // Clean press with a slow rate so no tick can interfere.
    rate = 4'd15;
    goto_cyc(10);
    c0 = cyc;
    btn = 1'b1;
    push_adv(c0 + 8);
    neg_at(c0 + 6);
    check("press_db_early", io_out[2], 1'b0);
    neg_at(c0 + 7);
    check("press_db_rise", io_out[2], 1'b1);
    neg_at(c0 + 9);
    check("press_count", io_out[6:3], exp_cnt);
    goto_cyc(c0 + 20);
    c1 = cyc;
    btn = 1'b0;
    neg_at(c1 + 6);
    check("release_db_hold", io_out[2], 1'b1);
    neg_at(c1 + 7);
    check("release_db_fall", io_out[2], 1'b0);

    // Three-cycle glitch is rejected.
    goto_cyc(c1 + 12);
    c0 = cyc;
    btn = 1'b1;
    goto_cyc(c0 + 3);
    btn = 1'b0;
    for (int i = 4; i <= 16; i += 4) begin
      neg_at(c0 + i);
      check("glitch_db", io_out[2], 1'b0);
    end
    check("glitch_count", io_out[6:3], exp_cnt);

    // Run at R=0: strobe every second cycle, count wraps.
    rate = 4'd0;
    goto_cyc(cyc + 5);
    c0 = cyc;
    c1 = c0 + 66;
    run = 1'b1;
    push_run(c0 + 4, c1 + 2, k_of(rate));
    neg_at(c0 + 2);
    check("run_led_pre", io_out[1], 1'b0);
    neg_at(c0 + 3);
    check("run_led_on", io_out[1], 1'b1);
    goto_cyc(c1);
    run = 1'b0;
    neg_at(c1 + 2);
    check("run_led_tail", io_out[1], 1'b1);
    neg_at(c1 + 3);
    check("run_led_off", io_out[1], 1'b0);
    neg_at(c1 + 8);
    check("run0_count", io_out[6:3], exp_cnt);

    // Run at R=3 with a button press that must be ignored.
    rate = 4'd3;
    goto_cyc(cyc + 5);
    c0 = cyc;
    c1 = c0 + 80;
    run = 1'b1;
    push_run(c0 + 4, c1 + 2, k_of(rate));
    goto_cyc(c0 + 20);
    btn = 1'b1;
    goto_cyc(c0 + 40);
    btn = 1'b0;
    goto_cyc(c1);
    run = 1'b0;
    neg_at(c1 + 10);
    check("run3_count", io_out[6:3], exp_cnt);
    check("run3_led_off", io_out[1], 1'b0);

    // Reset in the middle of a run.
    goto_cyc(cyc + 5);
    c0 = cyc;
    cr = c0 + 30;
    run = 1'b1;
    push_run(c0 + 4, cr, k_of(rate));
    goto_cyc(cr);
    rst = 1'b1;
    neg_at(cr + 1);
    check("midrun_reset_out", io_out, 8'h00);
    goto_cyc(cr + 2);
    rst = 1'b0;
    run = 1'b0;
    r_edge = cr + 2;
    exp_cnt = 4'd0;
    neg_at(cr + 3);
    check("midrun_release_out", io_out, 8'h00);

    // Long hold at R=0: a single strobe, plus auto-repeat when built in.
    rate = 4'd0;
    goto_cyc(cyc + 5);
    c0 = cyc;
    c1 = c0 + 40;
    btn = 1'b1;
    push_adv(c0 + 8);
`ifdef STEP_AUTOREPEAT_EN
    j = 0;
    for (int n = c0 + 8; n <= c1 + 6; n++) begin
      if (tick_at(n, 0)) begin
        j++;
        if (j > 8) push_adv(n + 1);
      end
    end
`else
    j = 0;
`endif
    goto_cyc(c1);
    btn = 1'b0;
    neg_at(c1 + 12);
    check("hold_db_off", io_out[2], 1'b0);
    check("hold_count", io_out[6:3], exp_cnt);

    // Rate above the prescaler width clamps to its top bit.
    rate = 4'd15;
    goto_cyc(cyc + 5);
    c0 = cyc;
    c1 = c0 + 4200;
    run = 1'b1;
    push_run(c0 + 4, c1 + 2, k_of(rate));
    goto_cyc(c1);
    run = 1'b0;
    neg_at(c1 + 6);
    check("clamp_count", io_out[6:3], exp_cnt);

    neg_at(cyc + 3);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_step_pacer.md
Name: seg_step_pacer

Overview:
Upstream pacing stage for the two-flop segment sequencer. It turns a raw push-button and a run switch into clean single-cycle advance strobes, either one per press or periodic from a prescaler. It also keeps a 4-bit step count for display. It lives in the standard 8-in/8-out user-module wrapper: io_in[0] is the clock, io_in[1] is the reset.

Parameters:
PRESCALE_W, 12, prescaler counter width in bits (min 4)
DEBOUNCE_CYCLES, 4, consecutive differing synchronised samples needed to accept a button level change (min 2)

Ports:
io_in[0]  input  1  clock; all state on rising edge
io_in[1]  input  1  reset; synchronous, active-high
io_in[2]  input  1  raw step button, asynchronous, active-high
io_in[3]  input  1  run switch, asynchronous, active-high
io_in[7:4]  input  4  rate select R; quasi-static, sampled directly
io_out[0]  output  1  adv: advance strobe, high exactly one cycle per event
io_out[1]  output  1  run_led: high while FSM is in RUN
io_out[2]  output  1  btn_db: debounced button level
io_out[6:3]  output  4  step count, modulo 16
io_out[7]  output  1  heartbeat: prescaler MSB

Behaviour:
- Reset (io_in[1] high at an edge) clears all state: synchronisers, debounce counter, btn_db, prescaler, FSM (to IDLE), count, adv. All outputs read 0 the cycle after. Reset mid-press or mid-run aborts with no strobe.
- Input sync: io_in[2] and io_in[3] each pass through a 2-flop synchroniser; logic uses only the second flop.
- Debounce:
  - If btn_sync != btn_db, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, btn_db <= btn_sync and the counter clears.
  - If btn_sync == btn_db, the counter clears, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Prescaler: free-running PRESCALE_W counter, wraps to 0.
  - k = min(R, PRESCALE_W-1).
  - tick = 1 when prescaler[k:0] are all ones, giving period 2^(k+1) cycles.
- FSM states: IDLE, STEP_HOLD, RUN.
  - IDLE: rising edge of btn_db (registered previous value) -> adv<=1, go STEP_HOLD. Else if run_sync -> RUN.
  - STEP_HOLD: stay while btn_db=1. On btn_db=0 -> IDLE. Run is re-evaluated from IDLE, so a pending run enters RUN one cycle later.
  - RUN: adv<=tick. Button ignored. run_sync=0 -> IDLE; any tick that cycle is suppressed.
  - Button edge and run high together in IDLE: the step wins.
- adv is registered: high for exactly one cycle, never on two consecutive cycles except in RUN with R=0 (period 2).
- Count increments by 1 on the edge after adv is high and wraps 15 -> 0. It never changes otherwise.
- Latency: a clean press held from edge 0 gives adv high after edge DEBOUNCE_CYCLES+3 (7 with the default), and count updates one edge later.

Optional Feature:
STEP_AUTOREPEAT_EN
- Defined: in STEP_HOLD, a 3-bit hold counter counts ticks while btn_db=1. After 8 ticks, each further tick produces an adv. Release clears the counter.
- Undefined: exactly one adv per press, regardless of hold time; no hold counter is present.

Decomposition:
- Package seg_pace_pkg holds:
  - state enum (IDLE=2'd0, STEP_HOLD=2'd1, RUN=2'd2)
  - default localparams for PRESCALE_W and DEBOUNCE_CYCLES
  - AUTOREPEAT_TICKS=8
- One natural sub-module: btn_debounce (2-flop sync + debounce counter, outputs btn_db). Instantiated once; the run switch uses only a bare synchroniser.

Test Plan:
- Reset: hold io_in[1] for 3 cycles with io_in[3:2]=2'b11 -> io_out=8'h00 throughout and the cycle after release; FSM in IDLE.
- Clean press: io_in[2] high for 20 cycles -> single adv after edge 7; io_out[6:3] 0->1; no further adv; release -> btn_db low after 6 edges.
- Glitch: io_in[2] high for 3 cycles, then low -> btn_db stays 0, no adv, count unchanged.
- Run, R=0: io_in[3]=1 -> RUN, io_out[1]=1, adv every 2 cycles; 32 strobes take count 0->15->0 (wrap); io_in[3]=0 -> adv stops within 3 cycles.
- Run, R=3: adv every 16 cycles. Press button during RUN -> no extra adv. Reset asserted mid-run -> all outputs 0 next cycle.
- STEP_AUTOREPEAT_EN with R=0: hold button 40 cycles -> first adv at edge 7, then repeating adv every 2 cycles after 8 ticks; without the macro -> only the first adv.
